// File: rtl/zpu_sdram_sequencer.sv
// Splits ZPU 8/16/32-bit accesses into 16-bit big-endian SDRAM beats, one beat per granted slot.
// Each beat is issued in the cycle after a grant that arrives while waiting; zpu_busy covers the whole access.
module zpu_sdram_sequencer #(
  parameter int ADDR_WIDTH = 22,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] zpu_adrs,
  input  logic [31:0]           zpu_data,
  input  logic                  zpu_read,
  input  logic                  zpu_write,
  input  logic                  zpu_halfword,
  input  logic                  zpu_byte,
  input  logic                  slot_grant,
  input  logic [15:0]           sdram_q,
  output logic                  zpu_busy,
  output logic                  zpu_done,
  output logic [31:0]           zpu_q,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_ub,
  output logic                  mem_lb
);

  typedef enum logic [2:0] {IDLE, WAIT_SLOT, ISSUE, WAIT_DATA, DONE} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [2:0] LAT     = 3'(RD_LATENCY);

  state_t                state;
  logic [ADDR_WIDTH-2:0] word_adr;
  logic [31:0]           data_r;
  logic [1:0]            size_r;
  logic                  is_rd;
  logic                  odd_r;
  logic                  beat;
  logic [2:0]            lat_cnt;
  logic [15:0]           hi_q;

  logic                  req_ok;
  logic [1:0]            req_sz;
  logic [ADDR_WIDTH-2:0] beat_addr;
  logic [15:0]           beat_wdata;
  logic                  beat_ub;
  logic                  beat_lb;
  logic                  last_beat;
  logic [31:0]           rd_result;

  always_comb begin
    req_ok = 1'b1;
    req_sz = SZ_WORD;
    case ({zpu_read, zpu_write, zpu_halfword, zpu_byte})
      4'b1000, 4'b0100: req_sz = SZ_WORD;
      4'b1010, 4'b0110: req_sz = SZ_HALF;
      4'b1001, 4'b0101: req_sz = SZ_BYTE;
      default:          req_ok = 1'b0;
    endcase
  end

  // A 32-bit access ignores address bit 1; the beat index supplies the low word-address bit.
  always_comb begin
    beat_addr  = word_adr;
    beat_wdata = {data_r[7:0], data_r[7:0]};
    beat_ub    = 1'b1;
    beat_lb    = 1'b1;
    last_beat  = 1'b1;
    rd_result  = {16'b0, sdram_q};
    case (size_r)
      SZ_WORD: begin
        beat_addr  = {word_adr[ADDR_WIDTH-2:1], beat};
        beat_wdata = beat ? data_r[15:0] : data_r[31:16];
        last_beat  = beat;
        rd_result  = {hi_q, sdram_q};
      end
      SZ_HALF: beat_wdata = data_r[15:0];
      default: begin
        beat_ub   = ~odd_r;
        beat_lb   = odd_r;
        rd_result = {24'b0, odd_r ? sdram_q[7:0] : sdram_q[15:8]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      word_adr  <= '0;
      data_r    <= '0;
      size_r    <= SZ_BYTE;
      is_rd     <= 1'b0;
      odd_r     <= 1'b0;
      beat      <= 1'b0;
      lat_cnt   <= '0;
      hi_q      <= '0;
      zpu_busy  <= 1'b0;
      zpu_done  <= 1'b0;
      zpu_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_ub    <= 1'b0;
      mem_lb    <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      zpu_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ok) begin
            word_adr <= zpu_adrs[ADDR_WIDTH-1:1];
            odd_r    <= zpu_adrs[0];
            data_r   <= zpu_data;
            size_r   <= req_sz;
            is_rd    <= zpu_read;
            beat     <= 1'b0;
            zpu_busy <= 1'b1;
            state    <= WAIT_SLOT;
          end
        end
        WAIT_SLOT: begin
          if (slot_grant) begin
            mem_addr  <= beat_addr;
            mem_wdata <= beat_wdata;
            mem_ub    <= beat_ub;
            mem_lb    <= beat_lb;
            mem_read  <= is_rd;
            mem_write <= ~is_rd;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_rd) begin
            lat_cnt <= 3'd1;
            state   <= WAIT_DATA;
          end else if (last_beat) begin
            zpu_done <= 1'b1;
            zpu_busy <= 1'b0;
            state    <= DONE;
          end else begin
            beat  <= 1'b1;
            state <= WAIT_SLOT;
          end
        end
        WAIT_DATA: begin
          // lat_cnt counts clocks since ISSUE; capture when it reaches the read latency.
          if (lat_cnt == LAT) begin
            if (!last_beat) begin
              hi_q  <= sdram_q;
              beat  <= 1'b1;
              state <= WAIT_SLOT;
            end else begin
              zpu_q    <= rd_result;
              zpu_done <= 1'b1;
              zpu_busy <= 1'b0;
              state    <= DONE;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zpu_sdram_sequencer.sv
// Directed bench: expected SDRAM commands and completions are queued as stimulus is driven.
module tb_zpu_sdram_sequencer;
  localparam int AW  = 22;
  localparam int RDL = 2;

  typedef struct {
    logic          rd;
    logic [AW-2:0] addr;
    logic [15:0]   wd;
    logic          ub;
    logic          lb;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] zpu_adrs;
  logic [31:0]   zpu_data;
  logic          zpu_read, zpu_write, zpu_halfword, zpu_byte;
  logic          slot_grant;
  logic [15:0]   sdram_q;
  logic          zpu_busy, zpu_done;
  logic [31:0]   zpu_q;
  logic [AW-2:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_read, mem_write, mem_ub, mem_lb;

  int checks   = 0;
  int failures = 0;

  cmd_t        cmd_q[$];
  logic [31:0] done_q[$];
  logic [15:0] rd_q[$];
  int          cd = 0;
  logic [15:0] pend = 16'h0;

  always #5 clk = ~clk;

  zpu_sdram_sequencer #(.ADDR_WIDTH(AW), .RD_LATENCY(RDL)) dut (
    .clk(clk), .reset(reset), .zpu_adrs(zpu_adrs), .zpu_data(zpu_data),
    .zpu_read(zpu_read), .zpu_write(zpu_write), .zpu_halfword(zpu_halfword),
    .zpu_byte(zpu_byte), .slot_grant(slot_grant), .sdram_q(sdram_q),
    .zpu_busy(zpu_busy), .zpu_done(zpu_done), .zpu_q(zpu_q), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ub(mem_ub), .mem_lb(mem_lb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, score commands/completions, model SDRAM read data.
  task automatic step();
    cmd_t e;
    @(posedge clk);
    #1;
    if (mem_read || mem_write) begin
      if (cmd_q.size() == 0) begin
        chk("unexpected_cmd", {30'b0, mem_read, mem_write}, 32'h0);
      end else begin
        e = cmd_q.pop_front();
        chk("cmd_type", {30'b0, mem_read, mem_write}, {30'b0, e.rd, ~e.rd});
        chk("cmd_addr", {11'b0, mem_addr}, {11'b0, e.addr});
        chk("cmd_ublb", {30'b0, mem_ub, mem_lb}, {30'b0, e.ub, e.lb});
        if (!e.rd) chk("cmd_wdata", {16'b0, mem_wdata}, {16'b0, e.wd});
      end
    end
    if (zpu_done) begin
      chk("done_busy", {31'b0, zpu_busy}, 32'h0);
      if (done_q.size() == 0) chk("unexpected_done", {31'b0, zpu_done}, 32'h0);
      else chk("zpu_q", zpu_q, done_q.pop_front());
    end
    if (cd > 0) begin
      cd--;
      sdram_q = (cd == 0) ? pend : 16'hDEAD;
    end else begin
      sdram_q = 16'hDEAD;
    end
    if (mem_read) begin
      cd   = RDL;
      pend = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0BAD;
    end
  endtask

  task automatic exp_cmd(input logic rd, input logic [AW-2:0] a, input logic [15:0] wd,
                         input logic ub, input logic lb);
    cmd_t c;
    c.rd = rd; c.addr = a; c.wd = wd; c.ub = ub; c.lb = lb;
    cmd_q.push_back(c);
  endtask

  task automatic req(input logic rd, input logic wr, input logic hw, input logic by,
                     input logic [AW-1:0] a, input logic [31:0] d, input logic grant_same);
    zpu_read = rd; zpu_write = wr; zpu_halfword = hw; zpu_byte = by;
    zpu_adrs = a; zpu_data = d; slot_grant = grant_same;
    step();
    zpu_read = 0; zpu_write = 0; zpu_halfword = 0; zpu_byte = 0; slot_grant = 0;
    zpu_data = 32'h0;
  endtask

  // Grants every 'period' clocks until zpu_done (or first mem_read); optional strobe while busy.
  task automatic run(input int period, input bit stop_on_rd, input int strobe_at);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      slot_grant = ((i % period) == (period - 1));
      if (i == strobe_at) begin
        zpu_write = 1; zpu_adrs = 22'h3FFFFC; zpu_data = 32'hFFFFFFFF;
      end
      step();
      slot_grant = 0; zpu_write = 0;
      hit = stop_on_rd ? mem_read : zpu_done;
    end
    if (!hit) begin
      checks++; failures++;
      $error("FAIL timeout observed=busy%0b expected=completion", zpu_busy);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1; zpu_adrs = 0; zpu_data = 0; zpu_read = 0; zpu_write = 0;
    zpu_halfword = 0; zpu_byte = 0; slot_grant = 0; sdram_q = 16'hDEAD;
    idle(3);
    chk("rst_outs", {26'b0, zpu_busy, zpu_done, mem_read, mem_write, mem_ub, mem_lb}, 32'h0);
    chk("rst_q", zpu_q, 32'h0);
    chk("rst_addr", {11'b0, mem_addr}, 32'h0);
    reset = 0;
    idle(2);

    // 32-bit write, grants every 4 clocks
    exp_cmd(0, 21'h80, 16'h1234, 1, 1);
    exp_cmd(0, 21'h81, 16'h5678, 1, 1);
    done_q.push_back(32'h0);
    req(0, 1, 0, 0, 22'h000100, 32'h12345678, 0);
    chk("busy_after_accept", {31'b0, zpu_busy}, 32'h1);
    run(4, 0, -1);
    idle(3);
    chk("busy_idle_t1", {31'b0, zpu_busy}, 32'h0);

    // misaligned 32-bit read
    exp_cmd(1, 21'h100, 16'h0, 1, 1);
    exp_cmd(1, 21'h101, 16'h0, 1, 1);
    rd_q.push_back(16'hCAFE); rd_q.push_back(16'hBABE);
    done_q.push_back(32'hCAFEBABE);
    req(1, 0, 0, 0, 22'h000202, 32'h0, 0);
    run(1, 0, -1);
    idle(2);

    // 8-bit write at odd byte: low data byte replicated
    exp_cmd(0, 21'h81, 16'hA5A5, 0, 1);
    done_q.push_back(32'hCAFEBABE);
    req(0, 1, 0, 1, 22'h000103, 32'hFFFFFFA5, 0);
    run(2, 0, -1);
    idle(2);

    // 8-bit reads (even/odd) and 16-bit read
    exp_cmd(1, 21'h81, 16'h0, 1, 0);
    rd_q.push_back(16'h7F3C); done_q.push_back(32'h0000007F);
    req(1, 0, 0, 1, 22'h000102, 32'h0, 0);
    run(3, 0, -1);
    idle(2);
    exp_cmd(1, 21'h82, 16'h0, 0, 1);
    rd_q.push_back(16'h7F3C); done_q.push_back(32'h0000003C);
    req(1, 0, 0, 1, 22'h000105, 32'h0, 0);
    run(2, 0, -1);
    idle(2);
    exp_cmd(1, 21'h82, 16'h0, 1, 1);
    rd_q.push_back(16'hBEEF); done_q.push_back(32'h0000BEEF);
    req(1, 0, 1, 0, 22'h000104, 32'h0, 0);
    run(1, 0, -1);
    idle(2);

    // illegal strobe combinations are ignored
    req(1, 1, 0, 0, 22'h000100, 32'h0, 0);
    chk("ignore_rdwr", {31'b0, zpu_busy}, 32'h0);
    req(0, 1, 1, 1, 22'h000100, 32'h0, 0);
    chk("ignore_hwbyte", {31'b0, zpu_busy}, 32'h0);
    idle(3);

    // grant coincident with request is not used; strobe while busy is ignored
    exp_cmd(0, 21'h83, 16'hBEAD, 1, 1);
    done_q.push_back(32'h0000BEEF);
    req(0, 1, 1, 0, 22'h000107, 32'h1111BEAD, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_early_cmd", {30'b0, mem_read, mem_write}, 32'h0);
    end
    chk("busy_waiting", {31'b0, zpu_busy}, 32'h1);
    run(3, 0, 1);
    idle(4);

    // reset in WAIT_DATA of a 32-bit read aborts it
    exp_cmd(1, 21'h000, 16'h0, 1, 1);
    rd_q.push_back(16'h1111);
    req(1, 0, 0, 0, 22'h000000, 32'h0, 0);
    run(2, 1, -1);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_busy", {31'b0, zpu_busy}, 32'h0);
    chk("abort_q", zpu_q, 32'h0);
    for (int i = 0; i < 6; i++) begin
      slot_grant = i[0];
      step();
    end
    slot_grant = 0;
    chk("abort_busy_late", {31'b0, zpu_busy}, 32'h0);
    chk("abort_q_late", zpu_q, 32'h0);

    exp_cmd(1, 21'h008, 16'h0, 1, 1);
    rd_q.push_back(16'h4242); done_q.push_back(32'h00004242);
    req(1, 0, 1, 0, 22'h000010, 32'h0, 0);
    run(2, 0, -1);
    idle(3);

    chk("cmd_q_drained", cmd_q.size(), 32'h0);
    chk("done_q_drained", done_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
